// File: rtl/conv_window_sequencer_if.sv
// Bus bundle between the core-side control and the CONV window sequencer.
// Carries the start request with the window descriptor, the synchronous
// data-memory read port and the busy/done/result return path.
//   master : core / memory side (drives start, base_addr, stride, kernel,
//            mem_rdata)
//   slave  : sequencer side (drives mem_rd, mem_addr, busy, done, result)
interface conv_window_sequencer_if #(
  parameter int ADDR_W = 18
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] stride;
  logic [71:0]       kernel;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              busy;
  logic              done;
  logic [7:0]        result;

  modport master (
    output start, base_addr, stride, kernel, mem_rdata,
    input  mem_rd, mem_addr, busy, done, result
  );

  modport slave (
    input  start, base_addr, stride, kernel, mem_rdata,
    output mem_rd, mem_addr, busy, done, result
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// CONV window sequencer: on an accepted start it reads the nine pixels of a
// 3x3 window from a synchronous data memory, multiply-accumulates each one
// with its signed kernel coefficient, then shifts, saturates and returns one
// unsigned 8-bit pixel.
// Ports:
//   clk_i  - system clock, all state changes on the rising edge
//   rst_i  - synchronous active-high reset
//   bus    - slave side of conv_window_sequencer_if (start/base_addr/stride/
//            kernel in, mem_rd/mem_addr out, mem_rdata in, busy/done/result out)
module conv_window_sequencer #(
  parameter int ADDR_W = 18,
  parameter int SHIFT  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  conv_window_sequencer_if.slave bus
);

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int ACC_W  = 21;
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(255);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_NORM,
    S_DONE
  } state_t;

  state_t                   state_q;
  logic [3:0]               k_q;
  logic [1:0]               col_q;
  logic [ADDR_W-1:0]        row_q;
  logic [ADDR_W-1:0]        stride_q;
  logic [ADDR_W-1:0]        mem_addr_q;
  logic                     mem_rd_q;
  logic                     busy_q;
  logic                     done_q;
  logic [DATA_W-1:0]        result_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;

  logic                     vld_p1;
  logic [3:0]               k_p1;
  logic signed [PROD_W-1:0] prod_p1;

  function automatic logic signed [COEF_W-1:0] coef_sel(
    input logic [71:0] kern,
    input logic [3:0]  idx
  );
    coef_sel = kern[int'(idx)*COEF_W +: COEF_W];
  endfunction

  // Arithmetic shift, then clamp to the unsigned pixel range.
  function automatic logic [DATA_W-1:0] norm_sat(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
    if (s[ACC_W-1])        norm_sat = '0;
    else if (s > PIX_MAX)  norm_sat = '1;
    else                   norm_sat = s[DATA_W-1:0];
  endfunction

  // Return stage: pixel for the read issued last cycle is on mem_rdata now.
  // Both operands are widened to the product width so the low PROD_W bits of
  // the multiply are the exact signed product.
  always_comb begin
    logic signed [PROD_W-1:0] coef_ext;
    logic signed [PROD_W-1:0] pix_ext;
    logic [COEF_W-1:0]        c;
    c        = coef_sel(bus.kernel, k_p1);
    coef_ext = {{(PROD_W-COEF_W){c[COEF_W-1]}}, c};
    pix_ext  = {{(PROD_W-DATA_W){1'b0}}, bus.mem_rdata};
    prod_p1  = coef_ext * pix_ext;
    acc_d    = acc_q + {{(ACC_W-PROD_W){prod_p1[PROD_W-1]}}, prod_p1};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      stride_q   <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      acc_q      <= '0;
      vld_p1     <= 1'b0;
      k_p1       <= '0;
    end else begin
      vld_p1 <= mem_rd_q;
      k_p1   <= k_q;
      if (vld_p1) acc_q <= acc_d;

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q    <= S_LOAD;
            row_q      <= bus.base_addr;
            stride_q   <= bus.stride;
            mem_addr_q <= bus.base_addr;
            mem_rd_q   <= 1'b1;
            busy_q     <= 1'b1;
            k_q        <= '0;
            col_q      <= '0;
            acc_q      <= '0;
          end
        end
        // Address walks column by column; a row step adds the latched stride
        // to the row base, so no multiplier is needed. Wraps modulo 2^ADDR_W.
        S_LOAD: begin
          if (k_q == 4'd8) begin
            state_q  <= S_DRAIN;
            mem_rd_q <= 1'b0;
          end else begin
            k_q <= k_q + 4'd1;
            if (col_q == 2'd2) begin
              col_q      <= '0;
              row_q      <= row_q + stride_q;
              mem_addr_q <= row_q + stride_q;
            end else begin
              col_q      <= col_q + 2'd1;
              mem_addr_q <= mem_addr_q + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          state_q <= S_NORM;
        end
        S_NORM: begin
          result_q <= norm_sat(acc_q);
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer. Two instances (SHIFT=0 and SHIFT=4) share
// the same stimulus. A cycle-indexed reference model derives busy, mem_rd,
// mem_addr, done and result from the window timing and a plain arithmetic
// sum over the bench's memory contents.
module tb_conv_window_sequencer;
  localparam int ADDR_W = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] stride;
  logic [71:0]       kernel;

  conv_window_sequencer_if #(.ADDR_W(ADDR_W)) if0 ();
  conv_window_sequencer_if #(.ADDR_W(ADDR_W)) if4 ();

  conv_window_sequencer #(.ADDR_W(ADDR_W), .SHIFT(0)) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if0.slave)
  );
  conv_window_sequencer #(.ADDR_W(ADDR_W), .SHIFT(4)) dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if4.slave)
  );

  assign if0.start = start;     assign if4.start = start;
  assign if0.base_addr = base_addr; assign if4.base_addr = base_addr;
  assign if0.stride = stride;   assign if4.stride = stride;
  assign if0.kernel = kernel;   assign if4.kernel = kernel;

  // Pixel memory (absent addresses read as 0).
  logic [7:0] mem [int];

  function automatic logic [7:0] mem_get(input logic [ADDR_W-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (if0.mem_rd) if0.mem_rdata <= mem_get(if0.mem_addr);
    if (if4.mem_rd) if4.mem_rdata <= mem_get(if4.mem_addr);
  end

  function automatic logic [ADDR_W-1:0] win_addr(input logic [ADDR_W-1:0] b,
                                                 input logic [ADDR_W-1:0] s,
                                                 input int k);
    logic [ADDR_W-1:0] r;
    r = b + s * ADDR_W'(k / 3) + ADDR_W'(k % 3);
    return r;
  endfunction

  function automatic logic [7:0] clamp8(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  // Reference model: t = cycle index within a window (0 = idle, 1..12).
  int                t;
  logic [ADDR_W-1:0] m_base, m_stride, e_addr;
  int                e_sum;
  logic [7:0]        e_res0, e_res4;

  always @(posedge clk) begin
    if (rst) begin
      t = 0; e_addr = '0; e_res0 = 8'd0; e_res4 = 8'd0;
    end else begin
      if (t == 0) begin
        if (start) begin
          t = 1; m_base = base_addr; m_stride = stride; e_sum = 0;
          for (int k = 0; k < 9; k++)
            e_sum += int'($signed(kernel[8*k +: 8])) *
                     int'(mem_get(win_addr(base_addr, stride, k)));
        end
      end else if (t == 12) t = 0;
      else t = t + 1;
      if (t >= 1 && t <= 9) e_addr = win_addr(m_base, m_stride, t - 1);
      if (t == 12) begin
        e_res0 = clamp8(e_sum);
        e_res4 = clamp8(e_sum >>> 4);
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  logic              mon_en = 1'b0;
  int                done_seen = 0;
  int                rd_seen = 0;
  logic [ADDR_W-1:0] addr_log [$];

  always @(negedge clk) begin
    if (mon_en) begin
      check("dut0.busy",     32'(if0.busy),     32'(t != 0));
      check("dut0.mem_rd",   32'(if0.mem_rd),   32'(t >= 1 && t <= 9));
      check("dut0.mem_addr", 32'(if0.mem_addr), 32'(e_addr));
      check("dut0.done",     32'(if0.done),     32'(t == 12));
      check("dut0.result",   32'(if0.result),   32'(e_res0));
      check("dut4.busy",     32'(if4.busy),     32'(t != 0));
      check("dut4.mem_rd",   32'(if4.mem_rd),   32'(t >= 1 && t <= 9));
      check("dut4.mem_addr", 32'(if4.mem_addr), 32'(e_addr));
      check("dut4.done",     32'(if4.done),     32'(t == 12));
      check("dut4.result",   32'(if4.result),   32'(e_res4));
      if (if0.done) done_seen++;
      if (if0.mem_rd) begin
        rd_seen++;
        addr_log.push_back(if0.mem_addr);
      end
    end
  end

  function automatic logic [71:0] kern_all(input logic [7:0] c);
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[8*k +: 8] = c;
    return r;
  endfunction

  task automatic fill_mem(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                          input logic [7:0] p);
    mem.delete();
    for (int k = 0; k < 9; k++) mem[int'(win_addr(b, s, k))] = p;
  endtask

  // One window starting at the next falling edge; extra start pulses and a
  // reset can be placed in given cycles (cycle 1 = first read cycle).
  task automatic run_window(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                            input int st_a, input int st_b, input int rst_c,
                            output int n_done, output int n_rd, output int log_i);
    int d0, r0;
    d0 = done_seen; r0 = rd_seen; log_i = addr_log.size();
    @(negedge clk);
    base_addr = b; stride = s; start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = (c == st_a) || (c == st_b);
      rst   = (c == rst_c);
    end
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_done = done_seen - d0;
    n_rd   = rd_seen - r0;
  endtask

  logic [ADDR_W-1:0] exp_a [9];
  int nd, nr, li;

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; stride = '0; kernel = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("reset.busy",     32'(if0.busy),     32'd0);
    check("reset.mem_rd",   32'(if0.mem_rd),   32'd0);
    check("reset.mem_addr", 32'(if0.mem_addr), 32'd0);
    check("reset.done",     32'(if0.done),     32'd0);
    check("reset.result",   32'(if0.result),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Address sequence
    mem.delete(); kernel = '0;
    run_window(18'd100, 18'd640, 0, 0, 0, nd, nr, li);
    exp_a = '{18'd100, 18'd101, 18'd102, 18'd740, 18'd741, 18'd742,
              18'd1380, 18'd1381, 18'd1382};
    check("addr.done_count", 32'(nd), 32'd1);
    check("addr.read_count", 32'(nr), 32'd9);
    if (addr_log.size() >= li + 9)
      for (int i = 0; i < 9; i++) check("addr.seq", 32'(addr_log[li+i]), 32'(exp_a[i]));

    // Identity kernel
    kernel = '0; kernel[39:32] = 8'd1;
    fill_mem(18'd1000, 18'd10, 8'hFF); mem[1011] = 8'h5A;
    run_window(18'd1000, 18'd10, 0, 0, 0, nd, nr, li);
    check("identity.result_s0", 32'(if0.result), 32'h5A);
    check("identity.result_s4", 32'(if4.result), 32'h05);

    // Box blur
    kernel = kern_all(8'd1); fill_mem(18'd2000, 18'd64, 8'd16);
    run_window(18'd2000, 18'd64, 0, 0, 0, nd, nr, li);
    check("blur.result_s4", 32'(if4.result), 32'd9);
    check("blur.result_s0", 32'(if0.result), 32'd144);

    // Positive saturation
    kernel = kern_all(8'd127); fill_mem(18'd3000, 18'd5, 8'd255);
    run_window(18'd3000, 18'd5, 0, 0, 0, nd, nr, li);
    check("satpos.result_s0", 32'(if0.result), 32'd255);
    check("satpos.result_s4", 32'(if4.result), 32'd255);

    // Reset in cycle 5, then a fresh window
    kernel = kern_all(8'd1); fill_mem(18'd500, 18'd20, 8'd16);
    run_window(18'd500, 18'd20, 0, 0, 5, nd, nr, li);
    check("rstmid.done_count", 32'(nd), 32'd0);
    check("rstmid.read_count", 32'(nr), 32'd5);
    check("rstmid.result",     32'(if0.result), 32'd0);
    check("rstmid.busy",       32'(if0.busy), 32'd0);
    run_window(18'd500, 18'd20, 0, 0, 0, nd, nr, li);
    check("rstmid.fresh_done",   32'(nd), 32'd1);
    check("rstmid.fresh_result", 32'(if4.result), 32'd9);

    // Negative saturation
    kernel = kern_all(8'hFF); fill_mem(18'd4000, 18'd7, 8'd200);
    run_window(18'd4000, 18'd7, 0, 0, 0, nd, nr, li);
    check("satneg.result_s0", 32'(if0.result), 32'd0);
    check("satneg.result_s4", 32'(if4.result), 32'd0);

    // Address wrap-around
    kernel = kern_all(8'd2); fill_mem(18'h3FFFF, 18'd1, 8'd3);
    run_window(18'h3FFFF, 18'd1, 0, 0, 0, nd, nr, li);
    exp_a = '{18'h3FFFF, 18'h00000, 18'h00001, 18'h00000, 18'h00001,
              18'h00002, 18'h00001, 18'h00002, 18'h00003};
    check("wrap.read_count", 32'(nr), 32'd9);
    if (addr_log.size() >= li + 9)
      for (int i = 0; i < 9; i++) check("wrap.seq", 32'(addr_log[li+i]), 32'(exp_a[i]));
    check("wrap.result_s0", 32'(if0.result), 32'd54);

    // start re-asserted while busy and while done is high
    kernel = '0; kernel[7:0] = 8'd3; fill_mem(18'd7000, 18'd100, 8'd40);
    run_window(18'd7000, 18'd100, 3, 12, 0, nd, nr, li);
    check("ctrl.done_count", 32'(nd), 32'd1);
    check("ctrl.read_count", 32'(nr), 32'd9);
    check("ctrl.result_s0",  32'(if0.result), 32'd120);
    check("ctrl.result_s4",  32'(if4.result), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Multi-cycle sequencer for the Filter-GPU CONV instruction. On start it issues nine pixel reads for one 3x3 window and multiply-accumulates each pixel with its kernel coefficient.
- After the reads it normalises and saturates the sum, then returns one 8-bit output pixel.
- Sits beside the control unit: the CONV decode drives start, busy stalls the core, result goes to the register-file write path.

Parameters:
- ADDR_W, 18, width of the data-memory address.
- SHIFT, 4, arithmetic right shift applied to the accumulator before saturation (legal range 0..15).

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a window; sampled only in IDLE.
- base_addr  input  ADDR_W  address of the window's top-left pixel; latched on an accepted start.
- stride  input  ADDR_W  row pitch in pixels; latched on an accepted start.
- kernel  input  72  nine signed 8-bit coefficients; coef k = kernel[8k+7:8k], k = row*3+col. Must be held stable while busy.
- mem_rd  output  1  read strobe to data memory.
- mem_addr  output  ADDR_W  read address.
- mem_rdata  input  8  unsigned pixel; valid exactly one cycle after mem_rd (synchronous RAM).
- busy  output  1  high while a window is in progress; used as core stall.
- done  output  1  one-cycle pulse when result is valid.
- result  output  8  unsigned output pixel; holds until the next done.

Behaviour:
- Reset: state=IDLE, k=0, acc=0, mem_rd=0, mem_addr=0, busy=0, done=0, result=0.
- Reset mid-operation returns to IDLE on the next edge. It produces no done and no memory read after the reset edge.
- FSM states and transitions:
  - IDLE: start=1 → LOAD. Latch base_addr and stride, clear acc and k.
  - LOAD (9 cycles, k=0..8):
    - mem_rd=1; mem_addr = base + (k/3)*stride + (k%3), computed modulo 2^ADDR_W (wrap-around allowed, no error).
    - k increments each cycle; after k=8 → DRAIN.
  - DRAIN (1 cycle): mem_rd=0; the last return (k=8) is accumulated → NORM.
  - NORM (1 cycle): s = acc >>> SHIFT (arithmetic). result = 0 if s<0, 255 if s>255, else s[7:0] → DONE.
  - DONE (1 cycle): done=1 → IDLE.
- Accumulation:
  - In every cycle following a mem_rd, acc += signed(coef[k-1]) * {0,mem_rdata}.
  - Product is 17-bit signed; acc is 21-bit signed. Worst case |9*255*128| = 293760 fits, so there is no overflow.
- Timing: start sampled at edge 0. mem_rd is high in cycles 1..9, DRAIN is cycle 10, NORM cycle 11, done=1 in cycle 12. Total latency 12 cycles.
- busy=1 in every state except IDLE (cycles 1..12). busy=0 in the cycle after done.
- start while busy is ignored: not queued, no effect on the current window. start in the same cycle done is high is also ignored. Back-to-back windows are possible from the cycle after done.
- result changes only on the NORM→DONE edge and otherwise holds.
- mem_addr holds its last value when mem_rd=0.

Test Plan:
- Address sequence: base_addr=100, stride=640, start pulse → mem_addr in cycles 1..9 = 100,101,102,740,741,742,1380,1381,1382 with mem_rd=1; done exactly in cycle 12; busy high in cycles 1..12 only.
- Identity kernel: coef4=1, others 0, SHIFT=0, centre pixel 0x5A, others 0xFF → result=0x5A.
- Box blur: all coef=1, all pixels 16, SHIFT=4 → acc=144, result=9.
- Saturation:
  - all coef=127, pixels 255, SHIFT=0 → result=255.
  - all coef=-1, pixels 200 → result=0.
- Wrap-around: base_addr=0x3FFFF, stride=1 → addresses 0x3FFFF,0x00000,0x00001,0x00000,0x00001,0x00002,0x00001,0x00002,0x00003.
- Control corners:
  - start re-asserted in cycles 3 and 12 → exactly one done and nine reads.
  - reset asserted in cycle 5 (k=4) → IDLE next cycle, busy=0, mem_rd=0, no done, result unchanged at 0; a fresh start afterwards completes normally.
